xadc_drp_sequencer: RTL and testbench

XADC_DRP_SEQUENCER -- requirements
Module: xadc_drp_sequencer

---
 rtl/xadc_pkg.sv | 19 +
 rtl/xadc_avg.sv | 78 +++++++
 rtl/xadc_drp_sequencer.sv | 150 +++++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC DRP read/write sequencer.
package xadc_pkg;

    localparam int unsigned DRP_ADDR_W = 7;
    localparam int unsigned DRP_DATA_W = 16;
    localparam int unsigned ADC_RES    = 12;

    localparam logic [DRP_ADDR_W-1:0] ADC_OUTPUT_ADDR = 7'h10;

    // DRP transaction sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_e;

endpackage

// File: rtl/xadc_avg.sv
// Per-channel sample averager: accumulates 2^AVG_LOG2 ADC reads, emits the
// truncated mean, and owns the round-robin channel pointer.
module xadc_avg
    import xadc_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned AVG_LOG2 = 2,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_ok_i,
    input  logic               rd_abort_i,
    input  logic [ADC_RES-1:0] rd_data_i,
    output logic [CH_W-1:0]    ch_o,
    output logic               smp_valid_o,
    output logic [CH_W-1:0]    smp_ch_o,
    output logic [ADC_RES-1:0] smp_data_o
);

    localparam int unsigned ACC_W = ADC_RES + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CH_W-1:0]    ch_q;
    logic [CH_W-1:0]    ch_d;
    logic               smp_valid_q;
    logic [CH_W-1:0]    smp_ch_q;
    logic [ADC_RES-1:0] smp_data_q;

    // Running sum including the read landing this cycle, and the wrapped next channel
    always_comb begin
        acc_d = acc_q + ACC_W'(rd_data_i);
        ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
    end

    // Accumulate reads; on the last read of a block publish the mean and move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_data_q  <= '0;
        end else begin
            smp_valid_q <= 1'b0;
            if (rd_abort_i) begin
                acc_q <= '0;
                cnt_q <= '0;
                ch_q  <= ch_d;
            end else if (rd_ok_i) begin
                if (cnt_q == CNT_LAST) begin
                    smp_valid_q <= 1'b1;
                    smp_ch_q    <= ch_q;
                    smp_data_q  <= ADC_RES'(acc_d >> AVG_LOG2);
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ch_q        <= ch_d;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign ch_o        = ch_q;
    assign smp_valid_o = smp_valid_q;
    assign smp_ch_o    = smp_ch_q;
    assign smp_data_o  = smp_data_q;

endmodule

// File: rtl/xadc_drp_sequencer.sv
// XADC DRP sequencer: round-robin status reads with averaging, interleaved
// config writes (writes take priority), and a per-transaction DRDY timeout.
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter int unsigned              NUM_CH    = 4,
    parameter logic [DRP_ADDR_W-1:0]    BASE_ADDR = ADC_OUTPUT_ADDR,
    parameter int unsigned              AVG_LOG2  = 2,
    parameter int unsigned              TIMEOUT   = 64,
    localparam int unsigned             CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_en,
    input  logic                  wr_req,
    input  logic [DRP_ADDR_W-1:0] wr_addr,
    input  logic [DRP_DATA_W-1:0] wr_data,
    output logic                  wr_ack,
    output logic                  DCLK,
    output logic [DRP_DATA_W-1:0] DI,
    input  logic [DRP_DATA_W-1:0] DO,
    output logic [DRP_ADDR_W-1:0] DADDR,
    output logic                  DWE,
    output logic                  DEN,
    input  logic                  DRDY,
    output logic                  smp_valid,
    output logic [CH_W-1:0]       smp_ch,
    output logic [ADC_RES-1:0]    smp_data,
    output logic                  timeout_err
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_e                  state_q;
    logic [TIMER_W-1:0]      timer_q;
    logic                    den_q;
    logic                    dwe_q;
    logic [DRP_ADDR_W-1:0]   daddr_q;
    logic [DRP_ADDR_W-1:0]   daddr_d;
    logic [DRP_DATA_W-1:0]   di_q;
    logic                    wr_ack_q;
    logic                    timeout_err_q;
    logic [CH_W-1:0]         ch;
    logic                    timer_hit;
    logic                    rd_ok;
    logic                    rd_abort;
    logic [3:0]              do_lsb_unused;

    assign DCLK = clk;

    // Status register address of the channel currently being scanned
    always_comb begin
        daddr_d   = BASE_ADDR + DRP_ADDR_W'(ch);
        timer_hit = (timer_q == TIMER_LAST);
        rd_ok     = (state_q == RD_WAIT) && DRDY;
        rd_abort  = (state_q == RD_WAIT) && !DRDY && timer_hit;
    end

    assign do_lsb_unused = DO[3:0];

    // Transaction FSM with registered DRP strobes, write ack and timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            den_q         <= 1'b0;
            dwe_q         <= 1'b0;
            daddr_q       <= BASE_ADDR;
            di_q          <= '0;
            wr_ack_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            den_q    <= 1'b0;
            dwe_q    <= 1'b0;
            wr_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    // wr_req is still high in the ack cycle; skip it there so one request = one write
                    if (wr_req && !wr_ack_q) begin
                        state_q <= WR_REQ;
                        den_q   <= 1'b1;
                        dwe_q   <= 1'b1;
                        daddr_q <= wr_addr;
                        di_q    <= wr_data;
                    end else if (scan_en) begin
                        state_q <= RD_REQ;
                        den_q   <= 1'b1;
                        daddr_q <= daddr_d;
                    end
                end
                RD_REQ: begin
                    timer_q <= '0;
                    state_q <= RD_WAIT;
                end
                WR_REQ: begin
                    timer_q <= '0;
                    state_q <= WR_WAIT;
                end
                RD_WAIT: begin
                    if (DRDY) begin
                        state_q <= IDLE;
                    end else if (timer_hit) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (DRDY) begin
                        wr_ack_q <= 1'b1;
                        state_q  <= IDLE;
                    end else if (timer_hit) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DEN         = den_q;
    assign DWE         = dwe_q;
    assign DADDR       = daddr_q;
    assign DI          = di_q;
    assign wr_ack      = wr_ack_q;
    assign timeout_err = timeout_err_q;

    // Averaging datapath and channel pointer
    xadc_avg #(
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk         (clk),
        .rst         (rst),
        .rd_ok_i     (rd_ok),
        .rd_abort_i  (rd_abort),
        .rd_data_i   (DO[DRP_DATA_W-1:4]),
        .ch_o        (ch),
        .smp_valid_o (smp_valid),
        .smp_ch_o    (smp_ch),
        .smp_data_o  (smp_data)
    );

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer: a pass-through instance (AVG_LOG2=0)
// and an averaging instance (AVG_LOG2=2), each with a small DRP responder.
module tb_xadc_drp_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int den_dbl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance 0: NUM_CH=4, AVG_LOG2=0 ----------------
    logic        rst0 = 1'b1, scan0 = 1'b0, wr_req0 = 1'b0;
    logic [6:0]  wr_addr0 = '0;
    logic [15:0] wr_data0 = '0;
    logic        wr_ack0, dclk0, dwe0, den0, smpv0, to0;
    logic        drdy0 = 1'b0;
    logic [15:0] di0;
    logic [15:0] do0 = '0;
    logic [6:0]  daddr0;
    logic [1:0]  smpch0;
    logic [11:0] smpd0;

    xadc_drp_sequencer #(.NUM_CH(4), .BASE_ADDR(7'h10), .AVG_LOG2(0), .TIMEOUT(64)) u_dut0 (
        .clk(clk), .rst(rst0), .scan_en(scan0),
        .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ack(wr_ack0),
        .DCLK(dclk0), .DI(di0), .DO(do0), .DADDR(daddr0), .DWE(dwe0), .DEN(den0), .DRDY(drdy0),
        .smp_valid(smpv0), .smp_ch(smpch0), .smp_data(smpd0), .timeout_err(to0)
    );

    // ---------------- instance 2: NUM_CH=4, AVG_LOG2=2 ----------------
    logic        rst2 = 1'b1, scan2 = 1'b0, wr_req2 = 1'b0;
    logic [6:0]  wr_addr2 = '0;
    logic [15:0] wr_data2 = '0;
    logic        wr_ack2, dclk2, dwe2, den2, smpv2, to2;
    logic        drdy2 = 1'b0;
    logic [15:0] di2;
    logic [15:0] do2 = '0;
    logic [6:0]  daddr2;
    logic [1:0]  smpch2;
    logic [11:0] smpd2;

    xadc_drp_sequencer #(.NUM_CH(4), .BASE_ADDR(7'h10), .AVG_LOG2(2), .TIMEOUT(64)) u_dut2 (
        .clk(clk), .rst(rst2), .scan_en(scan2),
        .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ack(wr_ack2),
        .DCLK(dclk2), .DI(di2), .DO(do2), .DADDR(daddr2), .DWE(dwe2), .DEN(den2), .DRDY(drdy2),
        .smp_valid(smpv2), .smp_ch(smpch2), .smp_data(smpd2), .timeout_err(to2)
    );

    // Responder 0: DRDY 3 cycles after DEN, DO = channel * 16'h1000
    int w0 = 0;
    always @(negedge clk) begin
        drdy0 = 1'b0;
        if (den0) w0 = 3;
        else if (w0 > 0) begin
            w0--;
            if (w0 == 0) begin
                drdy0 = 1'b1;
                do0   = 16'(daddr0 - 7'h10) * 16'h1000;
            end
        end
    end

    // Responder 2: DRDY 3 cycles after DEN, read data from queue q2; hold2 mutes it
    int          w2 = 0;
    int          nrd2 = 0;
    logic        we2 = 1'b0;
    logic        hold2 = 1'b0;
    logic [15:0] q2[$];
    always @(negedge clk) begin
        if (!hold2) drdy2 = 1'b0;
        if (hold2) w2 = 0;
        else if (den2) begin
            w2  = 3;
            we2 = dwe2;
        end else if (w2 > 0) begin
            w2--;
            if (w2 == 0) begin
                drdy2 = 1'b1;
                if (we2) do2 = 16'hDEAD;
                else begin
                    nrd2++;
                    if (q2.size() > 0) do2 = q2.pop_front();
                    else do2 = 16'h0000;
                end
            end
        end
    end

    // Monitors
    logic [1:0]  smp0_ch[$];
    logic [11:0] smp0_d[$];
    logic [6:0]  den0_addr[$];
    logic [1:0]  smp2_ch[$];
    logic [11:0] smp2_d[$];
    logic [6:0]  den2_addr[$];
    logic        den2_we[$];
    logic [15:0] den2_di[$];
    int          nack2 = 0;
    logic        den0_prev = 1'b0, den2_prev = 1'b0;

    always @(negedge clk) begin
        if (smpv0) begin smp0_ch.push_back(smpch0); smp0_d.push_back(smpd0); end
        if (den0) den0_addr.push_back(daddr0);
        if (smpv2) begin smp2_ch.push_back(smpch2); smp2_d.push_back(smpd2); end
        if (den2) begin den2_addr.push_back(daddr2); den2_we.push_back(dwe2); den2_di.push_back(di2); end
        if (wr_ack2) nack2++;
        if ((den0 && den0_prev) || (den2 && den2_prev)) den_dbl++;
        den0_prev = den0;
        den2_prev = den2;
    end

    task automatic reset2();
        scan2 = 1'b0; wr_req2 = 1'b0; hold2 = 1'b1; drdy2 = 1'b0;
        q2.delete();
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        #1;
        hold2 = 1'b0; nrd2 = 0; nack2 = 0;
        smp2_ch.delete(); smp2_d.delete();
        den2_addr.delete(); den2_we.delete(); den2_di.delete();
    endtask

    task automatic wait_smp2(input int n, input string tag);
        int b = 0;
        while (smp2_ch.size() < n && b < 500) begin @(negedge clk); #1; b++; end
        chk(tag, 32'(smp2_ch.size() >= n), 32'd1);
    endtask

    task automatic do_write2(input logic [6:0] a, input logic [15:0] d, input string tag);
        int b = 0;
        wr_addr2 = a; wr_data2 = d; wr_req2 = 1'b1;
        while (!wr_ack2 && b < 500) begin @(negedge clk); b++; end
        wr_req2 = 1'b0;
        chk(tag, 32'(wr_ack2), 32'd1);
    endtask

    initial begin
        int b;
        int lat;

        // ---- reset values and pass-through scan on instance 0 ----
        repeat (3) @(negedge clk);
        chk("rst_den",   32'(den0),   32'd0);
        chk("rst_dwe",   32'(dwe0),   32'd0);
        chk("rst_daddr", 32'(daddr0), 32'h10);
        chk("rst_di",    32'(di0),    32'd0);
        chk("rst_wrack", 32'(wr_ack0), 32'd0);
        chk("rst_smpv",  32'(smpv0),  32'd0);
        chk("rst_smpch", 32'(smpch0), 32'd0);
        chk("rst_smpd",  32'(smpd0),  32'd0);
        chk("rst_to",    32'(to0),    32'd0);
        chk("dclk",      32'(dclk0),  32'(clk));
        rst0 = 1'b0;
        scan0 = 1'b1;
        b = 0;
        while (smp0_ch.size() < 5 && b < 400) begin @(negedge clk); #1; b++; end
        scan0 = 1'b0;
        chk("pt_count", 32'(smp0_ch.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pt_ch%0d", i),   32'(smp0_ch[i]), 32'(i % 4));
            chk($sformatf("pt_data%0d", i), 32'(smp0_d[i]),  32'((i % 4) * 256));
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("pt_addr%0d", i), 32'(den0_addr[i]), 32'(16 + i));

        // ---- averaging: 1,2,3,5 -> 11>>2 = 2 ----
        reset2();
        q2 = '{16'h0010, 16'h0020, 16'h0030, 16'h0050};
        scan2 = 1'b1;
        wait_smp2(1, "avg_seen");
        chk("avg_ch",   32'(smp2_ch[0]), 32'd0);
        chk("avg_data", 32'(smp2_d[0]),  32'h002);
        scan2 = 1'b0;
        repeat (10) @(negedge clk);

        // ---- write and scan requested together: write goes first ----
        reset2();
        scan2 = 1'b1;
        do_write2(7'h41, 16'h1234, "wr_ack_seen");
        repeat (12) @(negedge clk);
        chk("wr_first_addr", 32'(den2_addr[0]), 32'h41);
        chk("wr_first_we",   32'(den2_we[0]),   32'd1);
        chk("wr_first_di",   32'(den2_di[0]),   32'h1234);
        chk("wr_then_raddr", 32'(den2_addr[1]), 32'h10);
        chk("wr_then_rwe",   32'(den2_we[1]),   32'd0);
        chk("wr_ack_once",   32'(nack2),        32'd1);
        scan2 = 1'b0;
        repeat (10) @(negedge clk);

        // ---- read timeout ----
        reset2();
        hold2 = 1'b1;
        drdy2 = 1'b0;
        scan2 = 1'b1;
        b = 0;
        while (!den2 && b < 20) begin @(negedge clk); b++; end
        lat = 0;
        while (!to2 && lat < 200) begin @(negedge clk); lat++; end
        hold2 = 1'b0;
        chk("to_flag",    32'(to2), 32'd1);
        chk("to_latency", 32'(lat), 32'd65);
        chk("to_no_smp",  32'(smp2_ch.size()), 32'd0);
        q2 = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        wait_smp2(1, "to_next_seen");
        chk("to_next_ch",   32'(smp2_ch[0]), 32'd1);
        chk("to_next_data", 32'(smp2_d[0]),  32'h028);
        chk("to_sticky",    32'(to2),        32'd1);
        scan2 = 1'b0;
        repeat (10) @(negedge clk);

        // ---- reset during RD_WAIT, late DRDY ignored ----
        reset2();
        hold2 = 1'b1;
        drdy2 = 1'b0;
        scan2 = 1'b1;
        b = 0;
        while (!den2 && b < 20) begin @(negedge clk); b++; end
        repeat (2) @(negedge clk);
        rst2 = 1'b1;
        scan2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        drdy2 = 1'b1;
        do2 = 16'hFFF0;
        @(negedge clk);
        drdy2 = 1'b0;
        @(negedge clk);
        chk("rr_den",   32'(den2),   32'd0);
        chk("rr_daddr", 32'(daddr2), 32'h10);
        chk("rr_dwe",   32'(dwe2),   32'd0);
        chk("rr_di",    32'(di2),    32'd0);
        chk("rr_wrack", 32'(wr_ack2), 32'd0);
        chk("rr_smpv",  32'(smpv2),  32'd0);
        chk("rr_smpch", 32'(smpch2), 32'd0);
        chk("rr_smpd",  32'(smpd2),  32'd0);
        chk("rr_to",    32'(to2),    32'd0);
        hold2 = 1'b0;
        q2 = '{16'h0040, 16'h0040, 16'h0040, 16'h0040};
        scan2 = 1'b1;
        wait_smp2(1, "rr_next_seen");
        chk("rr_next_ch",   32'(smp2_ch[0]), 32'd0);
        chk("rr_next_data", 32'(smp2_d[0]),  32'h004);
        scan2 = 1'b0;
        repeat (10) @(negedge clk);

        // ---- write between reads 2 and 3, scan paused meanwhile ----
        reset2();
        q2 = '{16'h0100, 16'h0200};
        scan2 = 1'b1;
        b = 0;
        while (nrd2 < 2 && b < 100) begin @(negedge clk); #1; b++; end
        scan2 = 1'b0;
        chk("mid_reads", 32'(nrd2), 32'd2);
        repeat (6) @(negedge clk);
        do_write2(7'h42, 16'hBEEF, "mid_wack");
        repeat (3) @(negedge clk);
        chk("mid_no_smp", 32'(smp2_ch.size()), 32'd0);
        q2.push_back(16'h0300);
        q2.push_back(16'h0400);
        scan2 = 1'b1;
        wait_smp2(1, "mid_seen");
        chk("mid_ch",   32'(smp2_ch[0]), 32'd0);
        chk("mid_data", 32'(smp2_d[0]),  32'h028);
        scan2 = 1'b0;
        repeat (10) @(negedge clk);

        chk("den_single", 32'(den_dbl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
